traffic_lamp_sequencer: RTL and testbench



---
 rtl/traffic_lamp_sequencer.sv | 105 ++++++++++
 tb/tb_traffic_lamp_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/traffic_lamp_sequencer.sv
// Lamp-head sequencer behind the NS/EW grant controller: turns single-bit grants
// into red/amber/green with min-green hold, timed amber and all-red clearance.
module traffic_lamp_sequencer #(
    parameter int MIN_GREEN    = 10,
    parameter int AMBER_CYCLES = 4,
    parameter int CLEAR_CYCLES = 2,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       NSlite,
    input  logic       EWlite,
    output logic       ns_red,
    output logic       ns_amber,
    output logic       ns_green,
    output logic       ew_red,
    output logic       ew_amber,
    output logic       ew_green,
    output logic [2:0] phase,
    output logic       grant_fault
);

    typedef enum logic [2:0] {
        ST_STARTUP_RED = 3'd0,
        ST_NS_GREEN    = 3'd1,
        ST_NS_AMBER    = 3'd2,
        ST_RED_TO_EW   = 3'd3,
        ST_EW_GREEN    = 3'd4,
        ST_EW_AMBER    = 3'd5,
        ST_RED_TO_NS   = 3'd6,
        ST_UNUSED      = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] TIMER_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] GREEN_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] AMBER_LAST = CNT_W'(AMBER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             grant_fault_q;
    logic             req_ns, req_ew;
    logic             in_green;

    // A conflicting grant (both high) decodes to no request at all.
    assign req_ns   = NSlite & ~EWlite;
    assign req_ew   = EWlite & ~NSlite;
    assign in_green = (state_q == ST_NS_GREEN) || (state_q == ST_EW_GREEN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_STARTUP_RED;
            timer_q       <= '0;
            grant_fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (NSlite && EWlite) begin
                grant_fault_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STARTUP_RED: if (timer_q == CLEAR_LAST) state_d = ST_NS_GREEN;
            ST_NS_GREEN:    if (req_ew && timer_q >= GREEN_LAST) state_d = ST_NS_AMBER;
            ST_NS_AMBER:    if (timer_q == AMBER_LAST) state_d = ST_RED_TO_EW;
            ST_RED_TO_EW:   if (timer_q == CLEAR_LAST) state_d = ST_EW_GREEN;
            ST_EW_GREEN:    if (req_ns && timer_q >= GREEN_LAST) state_d = ST_EW_AMBER;
            ST_EW_AMBER:    if (timer_q == AMBER_LAST) state_d = ST_RED_TO_NS;
            ST_RED_TO_NS:   if (timer_q == CLEAR_LAST) state_d = ST_NS_GREEN;
            default:        state_d = ST_STARTUP_RED;
        endcase

        // Greens can last indefinitely, so the timer parks at full scale there.
        timer_d = timer_q + 1'b1;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (in_green && timer_q == TIMER_MAX) begin
            timer_d = timer_q;
        end
    end

    always_comb begin
        ns_red   = 1'b1;
        ns_amber = 1'b0;
        ns_green = 1'b0;
        ew_red   = 1'b1;
        ew_amber = 1'b0;
        ew_green = 1'b0;
        case (state_q)
            ST_NS_GREEN: begin ns_red = 1'b0; ns_green = 1'b1; end
            ST_NS_AMBER: begin ns_red = 1'b0; ns_amber = 1'b1; end
            ST_EW_GREEN: begin ew_red = 1'b0; ew_green = 1'b1; end
            ST_EW_AMBER: begin ew_red = 1'b0; ew_amber = 1'b1; end
            default:     ;
        endcase
    end

    assign phase       = state_q;
    assign grant_fault = grant_fault_q;

endmodule

// File: tb/tb_traffic_lamp_sequencer.sv
// Scoreboard bench: a schedule-based reference model predicts each cycle's lamps,
// phase and fault flag; a negedge monitor pops and compares.
module tb_traffic_lamp_sequencer;

    localparam int MIN_GREEN    = 10;
    localparam int AMBER_CYCLES = 4;
    localparam int CLEAR_CYCLES = 2;
    localparam int CNT_W        = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       NSlite = 1'b0;
    logic       EWlite = 1'b0;
    logic       ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green;
    logic [2:0] phase;
    logic       grant_fault;

    traffic_lamp_sequencer #(
        .MIN_GREEN   (MIN_GREEN),
        .AMBER_CYCLES(AMBER_CYCLES),
        .CLEAR_CYCLES(CLEAR_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .NSlite     (NSlite),
        .EWlite     (EWlite),
        .ns_red     (ns_red),
        .ns_amber   (ns_amber),
        .ns_green   (ns_green),
        .ew_red     (ew_red),
        .ew_amber   (ew_amber),
        .ew_green   (ew_green),
        .phase      (phase),
        .grant_fault(grant_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         ph;
        logic [5:0] lamps;
        logic       fault;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: current phase, a queue of already-committed future phases,
    // how many cycles the current green has been shown, and the sticky fault.
    int   m_phase;
    int   m_plan[$];
    int   m_age;
    logic m_fault;

    // {ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green}
    function automatic logic [5:0] lamps_of(input int p);
        case (p)
            1:       return 6'b001_100;
            2:       return 6'b010_100;
            4:       return 6'b100_001;
            5:       return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    function automatic exp_t snapshot();
        exp_t e;
        e.ph    = m_phase;
        e.lamps = lamps_of(m_phase);
        e.fault = m_fault;
        return e;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_plan.delete();
        for (int i = 0; i < CLEAR_CYCLES - 1; i++) m_plan.push_back(0);
        m_plan.push_back(1);
        m_age   = 0;
        m_fault = 1'b0;
    endtask

    task automatic model_step(input logic ns, input logic ew);
        bit req;
        int amb, red, nxt;
        if (ns && ew) m_fault = 1'b1;
        if (m_plan.size() > 0) begin
            m_phase = m_plan.pop_front();
            if (m_phase == 1 || m_phase == 4) m_age = 1;
        end else if (m_phase == 1 || m_phase == 4) begin
            req = (m_phase == 1) ? (ew && !ns) : (ns && !ew);
            if (req && m_age >= MIN_GREEN) begin
                amb = m_phase + 1;
                red = m_phase + 2;
                nxt = (m_phase == 1) ? 4 : 1;
                for (int i = 0; i < AMBER_CYCLES - 1; i++) m_plan.push_back(amb);
                for (int i = 0; i < CLEAR_CYCLES; i++) m_plan.push_back(red);
                m_plan.push_back(nxt);
                m_phase = amb;
            end else begin
                m_age++;
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_reset();
            sb_q.delete();
            sb_q.push_back(snapshot());
        end else begin
            model_step(NSlite, EWlite);
            sb_q.push_back(snapshot());
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("phase", int'(phase), e.ph);
            check("lamps", int'({ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green}), int'(e.lamps));
            check("grant_fault", int'(grant_fault), int'(e.fault));
        end
        check("ns_one_lamp", $countones({ns_red, ns_amber, ns_green}), 1);
        check("ew_one_lamp", $countones({ew_red, ew_amber, ew_green}), 1);
        check("no_dual_go", int'((ns_green | ns_amber) & (ew_green | ew_amber)), 0);
    end

    task automatic hold(input logic ns, input logic ew, input int n);
        NSlite = ns;
        EWlite = ew;
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_model_phase(input int p, input string name);
        int guard = 0;
        while (m_phase != p && guard < 200) begin
            @(posedge clk);
            #2;
            guard++;
        end
        if (guard >= 200) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d required=%0d", name, m_phase, p);
        end
    endtask

    initial begin
        bit dir;
        int r;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;

        // Startup with NS granted, then hand over to EW once min green allows.
        hold(1'b1, 1'b0, 3);
        hold(1'b0, 1'b1, 30);

        // In EW green past min green: one-cycle NS pulse, then EW again.
        hold(1'b0, 1'b1, 12);
        hold(1'b1, 1'b0, 1);
        hold(1'b0, 1'b1, 40);

        // Get NS green, hold it long, conflict, then a late EW request.
        NSlite = 1'b1;
        EWlite = 1'b0;
        wait_model_phase(1, "ns_green");
        hold(1'b1, 1'b0, 32);
        hold(1'b1, 1'b1, 2);
        NSlite = 1'b0;
        EWlite = 1'b1;
        wait_model_phase(2, "ns_amber");

        // Second amber cycle: asynchronous reset lands mid-cycle.
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_lamps", int'({ns_red, ns_amber, ns_green, ew_red, ew_amber, ew_green}), 6'b100_100);
        check("async_rst_fault", int'(grant_fault), 0);
        check("async_rst_phase", int'(phase), 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        hold(1'b1, 1'b0, 20);

        // Random grants: long runs in one direction, occasional idle or conflict.
        dir = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 24) == 0) dir = ~dir;
            r = $urandom_range(0, 15);
            if (r == 0)      hold(1'b1, 1'b1, 1);
            else if (r < 3)  hold(1'b0, 1'b0, 1);
            else             hold(~dir, dir, 1);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
